ifstmt_pipe_alu: RTL and testbench

IFSTMT_PIPE_ALU -- requirements
Module: ifstmt_pipe_alu

---
 rtl/ifstmt_pipe_alu.sv | 114 +++++++++++
 tb/tb_ifstmt_pipe_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifstmt_pipe_alu.sv
// Elastic valid/ready ALU: sum or product, optional running accumulator, and one
// or two output register stages, each stage a two-state EMPTY/FULL slot.

module ifstmt_pipe_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             full,
    output logic [WIDTH-1:0] q
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            q     <= '0;
        end else begin
            state <= state_nxt;
            if (load) q <= d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (drain && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign full = (state == FULL);
endmodule

module ifstmt_pipe_alu #(
    parameter int WIDTH = 32,
    parameter int OP    = 0,
    parameter int PIPE  = 1,
    parameter int ACCUM = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [15:0]      out_count
);
    logic [WIDTH-1:0] r, res, q1;
    logic             load1, drain1, full1, deliver;

    assign in_ready = !reset && (!full1 || drain1);
    assign load1    = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    generate
        if (OP == 1) begin : g_mul
            assign r = in_x * in_y;
        end else begin : g_add
            assign r = in_x + in_y;
        end

        // acc advances with each accepted beat, so it follows acceptance order
        if (ACCUM == 1) begin : g_acc
            logic [WIDTH-1:0] acc;
            assign res = in_clear ? r : acc + r;
            always_ff @(posedge clock) begin
                if (reset)      acc <= '0;
                else if (load1) acc <= res;
            end
        end else begin : g_pass
            logic unused_clear;
            assign unused_clear = in_clear;
            assign res = r;
        end
    endgenerate

    ifstmt_pipe_alu_stage #(.WIDTH(WIDTH)) u_s1 (
        .clock(clock), .reset(reset), .load(load1), .drain(drain1),
        .d(res), .full(full1), .q(q1)
    );

    generate
        if (PIPE == 1) begin : g_two
            logic load2, full2;
            // stage 2 refills from stage 1 in the same cycle it drains downstream
            assign load2     = full1 && (!full2 || deliver);
            assign drain1    = load2;
            assign out_valid = full2;
            ifstmt_pipe_alu_stage #(.WIDTH(WIDTH)) u_s2 (
                .clock(clock), .reset(reset), .load(load2), .drain(deliver),
                .d(q1), .full(full2), .q(out_a)
            );
        end else begin : g_one
            assign drain1    = deliver;
            assign out_valid = full1;
            assign out_a     = q1;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset)        out_count <= '0;
        else if (deliver) out_count <= out_count + 16'd1;
    end
endmodule

// File: tb/tb_ifstmt_pipe_alu.sv
// Bench for ifstmt_pipe_alu: four parameterisations driven one at a time against
// a queue-based reference model (result values, ready time, occupancy).

module tb_ifstmt_pipe_alu;
    localparam int N = 4;
    localparam int PW [N] = '{32, 8, 8, 4};
    localparam int PO [N] = '{0, 1, 0, 0};
    localparam int PP [N] = '{1, 0, 1, 0};
    localparam int PA [N] = '{0, 0, 1, 0};

    logic             clock, reset;
    logic [N-1:0]     iv, clr, ordy, ir, ov;
    logic [63:0]      x [N];
    logic [63:0]      y [N];
    logic [63:0]      oa [N];
    logic [15:0]      oc [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nacc   = 0;

    typedef struct { logic [63:0] v; int rdy_at; } exp_t;
    exp_t        q[$];
    logic [63:0] dlog[$];
    logic [63:0] macc [N];
    int          mcnt [N];

    genvar g;
    for (g = 0; g < N; g++) begin : g_dut
        logic [PW[g]-1:0] a;
        logic [15:0]      c;
        ifstmt_pipe_alu #(.WIDTH(PW[g]), .OP(PO[g]), .PIPE(PP[g]), .ACCUM(PA[g])) u_dut (
            .clock(clock), .reset(reset),
            .in_valid(iv[g]), .in_ready(ir[g]),
            .in_x(x[g][PW[g]-1:0]), .in_y(y[g][PW[g]-1:0]), .in_clear(clr[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]),
            .out_a(a), .out_count(c)
        );
        assign oa[g] = 64'(a);
        assign oc[g] = c;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] msk(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock of traffic on instance i, checked against the model before the edge.
    task automatic step(input int i, input bit v, input logic [63:0] xv, input logic [63:0] yv,
                        input bit c, input bit orv, input bit rst);
        logic [63:0] m, r, res;
        bit          eov, eir, dlv;
        @(negedge clock);
        reset   = rst;
        iv      = '0;
        iv[i]   = v;
        x[i]    = xv;
        y[i]    = yv;
        clr[i]  = c;
        ordy[i] = orv;
        #1;
        m   = msk(PW[i]);
        eov = (q.size() > 0) && (cyc >= q[0].rdy_at);
        dlv = eov && orv;
        eir = !rst && ((q.size() < PP[i] + 1) || dlv);
        chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(eov));
        if (eov) chk($sformatf("u%0d.out_a", i), oa[i], q[0].v);
        chk($sformatf("u%0d.in_ready", i), 64'(ir[i]), 64'(eir));
        chk($sformatf("u%0d.out_count", i), 64'(oc[i]), 64'(mcnt[i]));
        if (rst) begin
            q.delete();
            for (int k = 0; k < N; k++) begin
                mcnt[k] = 0;
                macc[k] = '0;
            end
        end else begin
            if (dlv) begin
                dlog.push_back(q[0].v);
                void'(q.pop_front());
                mcnt[i] = (mcnt[i] + 1) % 65536;
            end
            if (v && eir) begin
                r = (PO[i] == 1) ? (((xv & m) * (yv & m)) & m) : (((xv & m) + (yv & m)) & m);
                if (PA[i] == 1) begin
                    res     = c ? r : ((macc[i] + r) & m);
                    macc[i] = res;
                end else begin
                    res = r;
                end
                q.push_back('{v: res, rdy_at: cyc + PP[i] + 1});
                nacc++;
            end
        end
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 20 && q.size() > 0; k++) step(i, 0, '0, '0, 0, 1, 0);
        chk($sformatf("u%0d.drain_left", i), 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        iv = '0; clr = '0; ordy = '0;
        for (int k = 0; k < N; k++) begin
            x[k] = '0; y[k] = '0; macc[k] = '0; mcnt[k] = 0;
        end
        repeat (2) @(posedge clock);

        // reset state on every instance
        for (int i = 0; i < N; i++) begin
            step(i, 0, '0, '0, 0, 0, 1);
            chk($sformatf("u%0d.reset_out_a", i), oa[i], 64'd0);
        end
        // beat offered under reset is dropped; ready returns right after release
        step(0, 1, 64'd5, 64'd5, 0, 1, 1);
        step(0, 0, '0, '0, 0, 1, 0);
        step(0, 0, '0, '0, 0, 1, 0);

        // default config: 1+4, 2+3 with two-cycle latency
        dlog.delete();
        step(0, 1, 64'd1, 64'd4, 0, 1, 0);
        step(0, 1, 64'd2, 64'd3, 0, 1, 0);
        drain(0);
        step(0, 0, '0, '0, 0, 1, 0);
        chk("sum_first", dlog[0], 64'd5);
        chk("sum_second", dlog[1], 64'd5);
        chk("sum_count", 64'(oc[0]), 64'd2);

        // 8-bit product truncation, one-cycle latency
        dlog.delete();
        step(1, 1, 64'h10, 64'h11, 0, 1, 0);
        step(1, 0, '0, '0, 0, 1, 0);
        chk("mul_trunc", dlog[0], 64'h10);

        // accumulator with clear on third beat
        dlog.delete();
        step(2, 1, 64'd1, 64'd1, 0, 1, 0);
        step(2, 1, 64'd2, 64'd0, 0, 1, 0);
        step(2, 1, 64'd3, 64'd0, 1, 1, 0);
        drain(2);
        chk("acc_0", dlog[0], 64'd2);
        chk("acc_1", dlog[1], 64'd4);
        chk("acc_2", dlog[2], 64'd3);

        // backpressure: five cycles of out_ready low while streaming
        begin
            int n0, k;
            dlog.delete();
            n0 = nacc;
            for (int t = 0; t < 5; t++) begin
                k = nacc - n0;
                step(0, 1, 64'(10 * (k + 1)), 64'(k + 1), 0, 0, 0);
            end
            chk("bp_accepted", 64'(nacc - n0), 64'd2);
            drain(0);
            chk("bp_count", 64'(dlog.size()), 64'd2);
            chk("bp_order0", dlog[0], 64'd11);
            chk("bp_order1", dlog[1], 64'd22);
        end

        // reset with two results in flight
        step(0, 1, 64'd7, 64'd1, 0, 0, 0);
        step(0, 1, 64'd8, 64'd1, 0, 0, 0);
        step(0, 0, '0, '0, 0, 0, 1);
        step(0, 0, '0, '0, 0, 1, 0);
        chk("rst_flight_valid", 64'(ov[0]), 64'd0);
        chk("rst_flight_count", 64'(oc[0]), 64'd0);
        repeat (4) step(0, 0, '0, '0, 0, 1, 0);

        // 4-bit sum wrap
        dlog.delete();
        step(3, 1, 64'hF, 64'h1, 0, 1, 0);
        drain(3);
        chk("w4_wrap", dlog[0], 64'd0);

        // randomized traffic on each configuration, with one mid-run reset
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < 80; t++) begin
                step(i, ($urandom % 4) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom % 5) == 0, ($urandom % 4) != 0, (i == 2) && (t == 40));
            end
            drain(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
